// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults, types and helpers for the GPR file and its scoreboard
package gpr_pkg;
  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 5;
  localparam int DEPTH_D = 32;
  localparam int ZERO_REG_D = 1;
  localparam int BYPASS_D = 1;
  localparam int MAX_W = 1024;
  typedef logic [ADDR_W_D-1:0] gpr_addr_t;
  typedef logic [DATA_W_D-1:0] gpr_data_t;
  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_W/8-1:0] be);
    logic [MAX_W-1:0] m;
    for (int i = 0; i < MAX_W/8; i++) m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction
  // a register address that holds real state (in range and not the hard-wired zero)
  function automatic logic addr_ok(input int a, input int depth, input int zr);
    return a < depth && !(zr != 0 && a == 0);
  endfunction
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register busy bits with flush > reserve > writeback-clear priority
module gpr_scoreboard import gpr_pkg::*; #(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int ZERO_REG = ZERO_REG_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);
  logic [DEPTH-1:0] busy;
  logic [2**ADDR_W-1:0] busy_x;
  logic rsv_ok, wr_ok;
  assign rsv_ok = rsv_en && addr_ok(int'(rsv_addr), DEPTH, ZERO_REG);
  assign wr_ok = wr_en && addr_ok(int'(wr_addr), DEPTH, ZERO_REG);
  assign busy_x = (2**ADDR_W)'(busy);
  assign busy_a = addr_ok(int'(rd_addr_a), DEPTH, ZERO_REG) && busy_x[rd_addr_a];
  assign busy_b = addr_ok(int'(rd_addr_b), DEPTH, ZERO_REG) && busy_x[rd_addr_b];
  always_ff @(posedge clk or posedge reset)
    if (reset) busy <= '0;
    else for (int r = 0; r < DEPTH; r++)
      busy[r] <= flush ? 1'b0 : (rsv_ok && int'(rsv_addr) == r) ? 1'b1 : (wr_ok && int'(wr_addr) == r) ? 1'b0 : busy[r];
endmodule

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: 2R/1W byte-enabled register file with optional zero register, bypass and busy scoreboard
module gpr_file_sb import gpr_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int ZERO_REG = ZERO_REG_D,
  parameter int BYPASS = BYPASS_D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_busy_a,
  output logic                rd_busy_b,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                flush
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] stored_a, stored_b;
  logic wr_ok, hit_a, hit_b, sb_busy_a, sb_busy_b;
  assign wr_ok = wr_en && addr_ok(int'(wr_addr), DEPTH, ZERO_REG);
  gpr_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .reset(reset), .flush(flush), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .busy_a(sb_busy_a), .busy_b(sb_busy_b)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    else if (wr_ok) mem[wr_addr] <= DATA_W'(lane_merge(MAX_W'(mem[wr_addr]), MAX_W'(wr_data), (MAX_W/8)'(wr_be)));
  // outputs are forced quiet while reset is held, even if a bypass would otherwise forward
  always_comb begin
    stored_a = addr_ok(int'(rd_addr_a), DEPTH, ZERO_REG) ? mem[rd_addr_a] : '0;
    stored_b = addr_ok(int'(rd_addr_b), DEPTH, ZERO_REG) ? mem[rd_addr_b] : '0;
    hit_a = BYPASS != 0 && wr_ok && wr_addr == rd_addr_a;
    hit_b = BYPASS != 0 && wr_ok && wr_addr == rd_addr_b;
    rd_data_a = reset ? '0 : hit_a ? DATA_W'(lane_merge(MAX_W'(stored_a), MAX_W'(wr_data), (MAX_W/8)'(wr_be))) : stored_a;
    rd_data_b = reset ? '0 : hit_b ? DATA_W'(lane_merge(MAX_W'(stored_b), MAX_W'(wr_data), (MAX_W/8)'(wr_be))) : stored_b;
    rd_busy_a = !reset && !hit_a && sb_busy_a;
    rd_busy_b = !reset && !hit_b && sb_busy_b;
  end
endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: table-driven check of two configurations (default, and DEPTH=24/no zero reg/no bypass)
module tb_gpr_file_sb;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, rsv_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0] wr_be = '0;
  logic wr_en = 1'b0, rsv_en = 1'b0, flush = 1'b0;
  logic [31:0] da0, db0, da1, db1;
  logic ba0, bb0, ba1, bb1;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  gpr_file_sb u0 (
    .clk(clk), .reset(reset), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da0), .rd_data_b(db0), .rd_busy_a(ba0), .rd_busy_b(bb0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );
  gpr_file_sb #(.DEPTH(24), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .reset(reset), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da1), .rd_data_b(db1), .rd_busy_a(ba1), .rd_busy_b(bb1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );
  typedef struct {
    logic rst, we, re, fl;
    logic [4:0] wa, rsa, ra, rb;
    logic [31:0] wd;
    logic [3:0] be;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0] bz;
  } vec_t;
  typedef struct {
    int id;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0] bz;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  task automatic add(input logic [31:0] rst, we, wa, wd, be, re, rsa, fl, ra, rb, a0, b0, a1, b1, bz);
    vec_t v;
    v.rst = rst[0]; v.we = we[0]; v.wa = wa[4:0]; v.wd = wd; v.be = be[3:0];
    v.re = re[0]; v.rsa = rsa[4:0]; v.fl = fl[0]; v.ra = ra[4:0]; v.rb = rb[4:0];
    v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1; v.bz = bz[3:0];
    tbl.push_back(v);
  endtask
  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
    else passed++;
  endtask
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    cmp("data_a0", e.id, da0, e.a0);
    cmp("data_b0", e.id, db0, e.b0);
    cmp("data_a1", e.id, da1, e.a1);
    cmp("data_b1", e.id, db1, e.b1);
    cmp("busy", e.id, 32'({ba0, bb0, ba1, bb1}), 32'(e.bz));
  endtask
  task automatic expect_out(input int id, input logic [31:0] a0, b0, a1, b1, input logic [3:0] bz);
    exp_t e;
    e.id = id; e.a0 = a0; e.b0 = b0; e.a1 = a1; e.b1 = b1; e.bz = bz;
    sb.push_back(e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    // rst we wa wd be re rsa fl ra rb | a0 b0 a1 b1 busy{a0,b0,a1,b1}
    add(1, 1,  5, 32'hDEADBEEF, 'hF, 1,  5, 0,  5,  5, 0, 0, 0, 0, 'h0);
    add(0, 1,  5, 32'h00001234, 'hF, 0,  0, 0,  5,  5, 32'h1234, 32'h1234, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  5,  5, 32'h1234, 32'h1234, 32'h1234, 32'h1234, 'h0);
    add(0, 1,  0, 32'hFFFFFFFF, 'hF, 0,  0, 0,  0,  0, 0, 0, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  0,  0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 'h0);
    add(0, 1,  7, 32'h11223344, 'hF, 0,  0, 0,  7,  5, 32'h11223344, 32'h1234, 0, 32'h1234, 'h0);
    add(0, 1,  7, 32'hAABBCCDD, 'h5, 0,  0, 0,  7,  7, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 32'h11223344, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  7,  7, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 'h0);
    add(0, 1,  9, 32'h5A5A5A5A, 'hF, 0,  0, 0,  9,  9, 32'h5A5A5A5A, 32'h5A5A5A5A, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  9,  9, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 'h0);
    add(0, 0,  0, 0,            'h0, 1,  3, 0,  3,  3, 0, 0, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  3,  3, 0, 0, 0, 0, 'hF);
    add(0, 1,  3, 32'h33,       'hF, 0,  0, 0,  3,  3, 32'h33, 32'h33, 0, 0, 'h3);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  3,  3, 32'h33, 32'h33, 32'h33, 32'h33, 'h0);
    add(0, 1,  3, 32'h44,       'hF, 1,  3, 0,  3,  3, 32'h44, 32'h44, 32'h33, 32'h33, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  3,  3, 32'h44, 32'h44, 32'h44, 32'h44, 'hF);
    add(0, 0,  0, 0,            'h0, 1,  1, 0,  1,  2, 0, 0, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 1,  2, 0,  1,  2, 0, 0, 0, 0, 'hA);
    add(0, 0,  0, 0,            'h0, 1,  4, 0,  1,  2, 0, 0, 0, 0, 'hF);
    add(0, 0,  0, 0,            'h0, 1,  6, 1,  4,  3, 0, 32'h44, 0, 32'h44, 'hF);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  6,  4, 0, 0, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  1,  3, 0, 32'h44, 0, 32'h44, 'h0);
    add(0, 1, 30, 32'h77777777, 'hF, 1, 30, 0, 30, 30, 32'h77777777, 32'h77777777, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0, 30, 30, 32'h77777777, 32'h77777777, 0, 0, 'hC);
    add(0, 1, 30, 0,            'h0, 0,  0, 0, 30, 30, 32'h77777777, 32'h77777777, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0, 30, 30, 32'h77777777, 32'h77777777, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 1,  0, 0,  0,  0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  0,  0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 'h3);
    add(0, 1, 10, 32'hABCD,     'hF, 0,  0, 1, 10,  0, 32'hABCD, 0, 0, 32'hFFFFFFFF, 'h1);
    add(0, 0,  0, 0,            'h0, 0,  0, 0, 10,  0, 32'hABCD, 0, 32'hABCD, 32'hFFFFFFFF, 'h0);
    add(1, 1,  8, 32'h1,        'hF, 1,  8, 0, 10,  7, 0, 0, 0, 0, 'h0);
    add(0, 0,  0, 0,            'h0, 0,  0, 0,  8, 10, 0, 0, 0, 0, 'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      wr_be = tbl[i].be; rsv_en = tbl[i].re; rsv_addr = tbl[i].rsa; flush = tbl[i].fl;
      rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
      expect_out(i, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].bz);
      #1 check_out();
    end
    // asynchronous reset raised between clock edges must clear outputs without waiting for clk
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h00C0FFEE; wr_be = 4'hF; rsv_en = 1'b1; rsv_addr = 5'd13;
    @(negedge clk);
    wr_en = 1'b0; rsv_en = 1'b0; rd_addr_a = 5'd12; rd_addr_b = 5'd13;
    expect_out(100, 32'h00C0FFEE, 0, 32'h00C0FFEE, 0, 4'b0101);
    #1 check_out();
    #1 reset = 1'b1;
    expect_out(101, 0, 0, 0, 0, 4'h0);
    #1 check_out();
    @(negedge clk);
    reset = 1'b0;
    expect_out(102, 0, 0, 0, 0, 4'h0);
    #1 check_out();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the multi-cycle core, successor to the fixed 32x32 GPR file. It has two combinational read ports and one write port with byte enables. An optional hard-wired zero register and an optional write-to-read bypass are selectable by parameter. An integrated per-register busy scoreboard lets the control FSM stall on operands whose producing instruction has not yet written back.

Parameters:
DATA_W, 32, register width in bits (multiple of 8)
ADDR_W, 5, register address width
DEPTH, 32, number of registers (<= 2**ADDR_W)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data
rd_data_b  out  DATA_W  read port B data
rd_busy_a  out  1  port A register has an outstanding reservation
rd_busy_b  out  1  port B register has an outstanding reservation
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte-lane enables; lane i = bits [8i+7:8i]
rsv_en  in  1  reserve (mark busy) a destination register
rsv_addr  in  ADDR_W  register to reserve
flush  in  1  clear all busy bits (pipeline squash)

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on port reset.
- Reset clears all DEPTH registers and all busy bits immediately. Outputs during reset are rd_data=0 and rd_busy=0. Reset asserted mid-operation discards any write or reservation in that cycle.
- Write: on the rising edge with wr_en=1, each lane with wr_be[i]=1 is updated; other lanes hold. wr_be=0 is a no-op for data but still clears busy.
  - Writes to address 0 are ignored when ZERO_REG=1.
  - Writes to wr_addr >= DEPTH are ignored.
- Read: combinational from rd_addr, with zero cycles of latency.
  - Address 0 reads 0 when ZERO_REG=1.
  - Addresses >= DEPTH read 0 with busy=0.
- Bypass (BYPASS=1): if wr_en=1 and wr_addr==rd_addr (the address is valid and not the zero register), rd_data is the stored word with enabled lanes replaced by wr_data, and rd_busy is forced to 0. With BYPASS=0, reads return pre-edge state only; the new value is visible the next cycle.
- Both read ports hitting the same address, including the write address, return identical data.
- Scoreboard, next-state for busy[r], in priority order:
  - flush=1 -> 0 for all r. Concurrent data writes still complete.
  - rsv_en=1 and rsv_addr==r -> 1. A reservation beats a same-cycle write to the same register, because a new producer supersedes the old one.
  - wr_en=1 and wr_addr==r -> 0.
  - otherwise hold.
- Reservations of address 0 (when ZERO_REG=1) or of addresses >= DEPTH are ignored.
- rd_busy reflects registered busy state, subject to the bypass override above. A same-cycle rsv_en does not affect rd_busy until the next cycle.
- Reserving an already-busy register is legal and leaves it busy. A write to a non-busy register is legal.

Decomposition:
- Package gpr_pkg:
  - default parameter constants
  - typedefs gpr_addr_t (ADDR_W) and gpr_data_t (DATA_W)
  - function for the byte-lane merge of old data, new data and byte enables
- Sub-module gpr_scoreboard: DEPTH busy flops plus the flush/reserve/clear priority logic and two busy read ports, with async reset.
- The data array and bypass muxing stay in gpr_file_sb.

Test Plan:
1. Reset, then write x0000_1234 to r5 with wr_be=1111, read r5 on A next cycle -> rd_data_a=x0000_1234, rd_busy_a=0. Assert reset mid-stream -> rd_data_a=0 immediately.
2. Write xFFFF_FFFF to r0 (ZERO_REG=1), then read r0 on A and B -> both 0. Rerun with ZERO_REG=0 -> both xFFFF_FFFF.
3. Byte enables: r7=x1122_3344, then write xAABB_CCDD with wr_be=0101 -> r7=x11BB_33DD.
4. Bypass: read r9 (holds 0) while writing x5A5A_5A5A to r9 in the same cycle.
   - BYPASS=1 -> rd_data_a=x5A5A_5A5A in that cycle.
   - BYPASS=0 -> 0 in that cycle, x5A5A_5A5A the next cycle.
5. Scoreboard sequence:
   - rsv r3 -> rd_busy=1 on the next cycle.
   - write r3 -> busy=0 after the edge, and forced to 0 in the write cycle if BYPASS=1.
   - rsv r3 and write r3 in the same cycle -> busy stays 1.
6. Reserve r1, r2 and r4, then flush plus rsv r6 in the same cycle -> all busy=0 including r6. Out-of-range address with DEPTH=24 and address 30 -> reads 0, write and reserve ignored.
